// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock.
// Optional macro DIV_ZERO_DETECT_EN: short-circuit a zero divisor straight to DONE and raise dz.
module seq_divider #(
   parameter int DW = 8,
   parameter int VW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          dz
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q;
   logic [DW-1:0] q_q, q_d;
   logic [VW:0]   r_q, r_d;
   logic [VW-1:0] d_q;
   logic [CW-1:0] cnt_q;
   logic [VW:0]   t;
   logic [DW-1:0] quotient_q;
   logic [VW-1:0] remainder_q;
   logic          busy_q, done_q;

   // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
   always_comb begin
      t = {r_q[VW-1:0], q_q[DW-1]};
      if (t >= {1'b0, d_q}) begin
         r_d = t - {1'b0, d_q};
         q_d = {q_q[DW-2:0], 1'b1};
      end else begin
         r_d = t;
         q_d = {q_q[DW-2:0], 1'b0};
      end
   end

`ifdef DIV_ZERO_DETECT_EN
   logic dz_q;
   assign dz = dz_q;
`else
   assign dz = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         q_q         <= '0;
         r_q         <= '0;
         d_q         <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
         dz_q        <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  q_q   <= dividend;
                  d_q   <= divisor;
                  r_q   <= '0;
                  cnt_q <= '0;
`ifdef DIV_ZERO_DETECT_EN
                  if (divisor == '0) begin
                     state_q     <= DONE;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                     quotient_q  <= '1;
                     remainder_q <= dividend[VW-1:0];
                     dz_q        <= 1'b1;
                  end else begin
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                  end
`else
                  state_q <= RUN;
                  busy_q  <= 1'b1;
`endif
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               q_q   <= q_d;
               r_q   <= r_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == LAST_CNT) begin
                  state_q     <= DONE;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  quotient_q  <= q_d;
                  remainder_q <= r_d[VW-1:0];
`ifdef DIV_ZERO_DETECT_EN
                  dz_q        <= 1'b0;
`endif
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle restoring divider: 8-bit dividend by 4-bit divisor, giving an 8-bit quotient and a 4-bit remainder. It is the inverse companion of the 4-bit multiplier. It sits beside that multiplier in the arithmetic datapath and recovers operands from products: feeding it {product, b} returns a with remainder 0. One quotient bit is produced per clock, with a start/busy/done handshake.

## Interface
- DW, 8: dividend and quotient width.
- VW, 4: divisor and remainder width; must satisfy VW ≤ DW.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- start  in  1  request; sampled only while busy=0.
- dividend  in  DW  numerator (unsigned); sampled with an accepted start.
- divisor  in  VW  denominator (unsigned); sampled with an accepted start.
- busy  out  1  high while an iteration is in progress.
- done  out  1  single-cycle pulse when results are valid.
- quotient  out  DW  result quotient; held until the next completion.
- remainder  out  VW  result remainder; held until the next completion.
- dz  out  1  divide-by-zero flag; valid with done; held like the results.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - DONE.
- Acceptance: start=1 in IDLE or DONE is accepted.
  - On acceptance: latch dividend into shift register q, latch divisor into d, clear partial remainder r (VW+1 bits), clear counter (0..DW-1), go to RUN.
  - start is ignored in RUN.
- RUN step, once per cycle:
  - t = {r[VW-1:0], q[DW-1]}.
  - If t ≥ d: r = t − d and qbit = 1; otherwise r = t and qbit = 0.
  - q = {q[DW-2:0], qbit}.
- After the DW-th step:
  - quotient ← q, remainder ← r[VW-1:0], dz ← 0.
  - Go to DONE.
- DONE lasts one cycle with done=1. Next state is RUN if start=1, otherwise IDLE.
- Arithmetic is unsigned and exact. r never exceeds 2·d−1, so VW+1 bits suffice.
- Divisor 0 without early detection: the algorithm naturally yields quotient = all ones and remainder = dividend[VW-1:0].
- Reset, asynchronous and valid at any time including mid-RUN:
  - State goes to IDLE and any operation in progress is abandoned.
  - busy=0, done=0, dz=0, quotient=0, remainder=0.
  - Internal q, r, d and counter are cleared.
- Inputs are don't-care outside the acceptance cycle; later changes to them do not affect a run in progress.

## Timing
- Start accepted at edge N:
  - busy=1 for the cycles following edges N..N+7.
  - done=1 for exactly the cycle following edge N+8.
  - quotient, remainder and dz update at edge N+8.
- Latency from accepted start to done is DW cycles (8 by default).
- Throughput: start held high during DONE is accepted, giving back-to-back operations every DW+1 cycles.
- busy and done are never both high.
- Outputs are registered; there is no combinational path from input to output.

## Configuration
- DIV_ZERO_DETECT_EN
  - Defined: an accepted start with divisor=0 skips RUN.
    - The next state is DONE directly; done pulses 1 cycle after acceptance and busy never rises.
    - quotient = all ones, remainder = dividend[VW-1:0], dz = 1.
    - A non-zero divisor behaves exactly as in the undefined case, with dz = 0.
  - Undefined:
    - dz is tied to 0.
    - A zero divisor runs the full DW steps and gives the same quotient and remainder values as above.

## Test plan
- 200/7: dividend=8'd200, divisor=4'd7 → quotient=28, remainder=4, dz=0; done exactly 8 cycles after acceptance; busy high for 8 cycles.
- Multiplier inverse and edge values:
  - 169/13 → 13 r 0.
  - 255/15 → 17 r 0.
  - 5/9 → 0 r 5.
  - 0/3 → 0 r 0.
  - 255/1 → 255 r 0.
- Divide by zero: dividend=8'hB6, divisor=0 → quotient=8'hFF, remainder=4'h6.
  - With DIV_ZERO_DETECT_EN: dz=1 and done 1 cycle after acceptance.
  - Without: dz=0 and done after 8 cycles.
- Back-to-back: 100/3 with start held through DONE, then 77/8 → first result 33 r 1; second done exactly 9 cycles after the first done, with result 9 r 5.
- Busy ignore: during a 200/7 run, pulse start with 50/5 at step 3 → result remains 28 r 4 and no extra done pulse.
- Reset mid-run:
  - Assert rst at step 4 of 200/7 → busy, done, quotient and remainder are 0 immediately, without waiting for a clock edge.
  - After release, a new 60/4 → 15 r 0 with normal latency.
